// File: rtl/oflow_MEM_buffer_define.sv
// Shared widths, slot count, state encoding and slot-selection helper
// for the oflow frame buffer writer and reader.
`ifndef OFLOW_MEM_BUFFER_DEFINE_SV
`define OFLOW_MEM_BUFFER_DEFINE_SV

`ifndef TOTAL_FRAME_NUM_WIDTH
`define TOTAL_FRAME_NUM_WIDTH 8
`endif
`ifndef NUM_OF_HISTORY_FRAMES_WIDTH
`define NUM_OF_HISTORY_FRAMES_WIDTH 3
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 5
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package oflow_MEM_buffer_define;

    localparam int NUM_SLOTS                   = 5;
    localparam int MAX_LINES_DEFAULT           = 30;
    localparam int SLOT_WIDTH                  = 3;
    localparam int TOTAL_FRAME_NUM_WIDTH       = `TOTAL_FRAME_NUM_WIDTH;
    localparam int NUM_OF_HISTORY_FRAMES_WIDTH = `NUM_OF_HISTORY_FRAMES_WIDTH;
    localparam int OFFSET_WIDTH                = `OFFSET_WIDTH;
    localparam int ADDR_WIDTH                  = `ADDR_WIDTH;

    typedef logic [1:0] state_t;

    localparam state_t idle_st  = 2'd0;
    localparam state_t clear_st = 2'd1;
    localparam state_t write_st = 2'd2;
    localparam state_t done_st  = 2'd3;

    // A depth of 0 behaves as 1; depths above the slot count are clamped so
    // the slot index can never leave the end_pointers array.
    function automatic logic [SLOT_WIDTH-1:0] slot_of(
        input logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame,
        input logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] depth_in
    );
        logic [TOTAL_FRAME_NUM_WIDTH-1:0] depth;
        if (depth_in == '0)
            depth = TOTAL_FRAME_NUM_WIDTH'(1);
        else if (depth_in > NUM_OF_HISTORY_FRAMES_WIDTH'(NUM_SLOTS))
            depth = TOTAL_FRAME_NUM_WIDTH'(NUM_SLOTS);
        else
            depth = TOTAL_FRAME_NUM_WIDTH'(depth_in);
        return SLOT_WIDTH'(frame % depth);
    endfunction

endpackage

`endif

// File: rtl/oflow_fsm_write.sv
// Write-side sequencer of the oflow history frame buffer: picks a slot per
// frame and tracks lines stored per slot. OFLOW_WRITE_OVERFLOW_PROTECT_EN drops excess lines.
module oflow_fsm_write
    import oflow_MEM_buffer_define::*;
#(
    parameter int MAX_LINES_PER_FRAME = MAX_LINES_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    reset_N,
    input  logic [`TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
    input  logic [`NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
    input  logic                                    start_write,
    input  logic                                    data_valid,
    input  logic                                    data_last,
    output logic                                    ready_to_write,
    output logic                                    we,
    output logic [`TOTAL_FRAME_NUM_WIDTH-1:0]       frame_to_write,
    output logic [`OFFSET_WIDTH-1:0]                offset_w,
    output logic [`ADDR_WIDTH-1:0]                  end_pointers [NUM_SLOTS],
    output logic                                    done_write,
    output logic                                    overflow
);

    state_t                  state;
    logic [SLOT_WIDTH-1:0]   slot;
    logic [`OFFSET_WIDTH-1:0] counter;
    logic                    accept;
    logic                    store;

    assign accept = (state == write_st) && data_valid;

`ifdef OFLOW_WRITE_OVERFLOW_PROTECT_EN
    logic full;
    logic overflow_q;

    // Once the slot is full, lines are still consumed but never written.
    assign full     = (counter == `OFFSET_WIDTH'(MAX_LINES_PER_FRAME));
    assign store    = accept && !full;
    assign overflow = overflow_q;
`else
    localparam logic [`OFFSET_WIDTH-1:0] LAST_OFFSET = `OFFSET_WIDTH'(MAX_LINES_PER_FRAME - 1);
    localparam logic [`ADDR_WIDTH-1:0]   MAX_POINTER = `ADDR_WIDTH'(MAX_LINES_PER_FRAME);

    assign store    = accept;
    assign overflow = 1'b0;
`endif

    assign ready_to_write = (state == write_st);
    assign we             = store;
    assign offset_w       = counter;
    assign done_write     = (state == done_st);

    // NOTE: non-blocking assignments throughout, so every register here updates
    // from pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state          <= idle_st;
            slot           <= '0;
            counter        <= '0;
            frame_to_write <= '0;
            // NOTE: end_pointers is a small register file, not a RAM, so it is
            // reset explicitly; a slot that was never written must read 0.
            for (int i = 0; i < NUM_SLOTS; i++)
                end_pointers[i] <= '0;
`ifdef OFLOW_WRITE_OVERFLOW_PROTECT_EN
            overflow_q     <= 1'b0;
`endif
        end else begin
            case (state)
                idle_st: begin
                    if (start_write) begin
                        frame_to_write <= frame_num;
                        slot           <= slot_of(frame_num, num_of_history_frames);
                        state          <= clear_st;
                    end
                end
                clear_st: begin
                    end_pointers[slot] <= '0;
                    counter            <= '0;
`ifdef OFLOW_WRITE_OVERFLOW_PROTECT_EN
                    overflow_q         <= 1'b0;
`endif
                    state              <= write_st;
                end
                write_st: begin
                    if (data_valid) begin
`ifdef OFLOW_WRITE_OVERFLOW_PROTECT_EN
                        if (full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            counter            <= counter + 1'b1;
                            end_pointers[slot] <= end_pointers[slot] + 1'b1;
                        end
`else
                        counter <= (counter == LAST_OFFSET) ? '0 : counter + 1'b1;
                        if (end_pointers[slot] != MAX_POINTER)
                            end_pointers[slot] <= end_pointers[slot] + 1'b1;
`endif
                        if (data_last)
                            state <= done_st;
                    end
                end
                done_st: state <= idle_st;
                default: state <= idle_st;
            endcase
        end
    end

endmodule

// File: tb/tb_oflow_fsm_write.sv
// Randomized self-checking bench for oflow_fsm_write against a per-frame
// line-count model of the history slots.
module tb_oflow_fsm_write;
    import oflow_MEM_buffer_define::*;

    localparam int MAX = MAX_LINES_DEFAULT;
    localparam int TFW = TOTAL_FRAME_NUM_WIDTH;
    localparam int NHW = NUM_OF_HISTORY_FRAMES_WIDTH;
    localparam int OW  = OFFSET_WIDTH;
    localparam int AW  = ADDR_WIDTH;

`ifdef OFLOW_WRITE_OVERFLOW_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_N;
    logic [TFW-1:0] frame_num;
    logic [NHW-1:0] num_of_history_frames;
    logic           start_write;
    logic           data_valid;
    logic           data_last;
    logic           ready_to_write;
    logic           we;
    logic [TFW-1:0] frame_to_write;
    logic [OW-1:0]  offset_w;
    logic [AW-1:0]  end_pointers [NUM_SLOTS];
    logic           done_write;
    logic           overflow;

    int vectors     = 0;
    int miscompares = 0;
    int ep_model [NUM_SLOTS];

    always #5 clk = ~clk;

    oflow_fsm_write #(
        .MAX_LINES_PER_FRAME(MAX)
    ) dut (
        .clk                  (clk),
        .reset_N              (reset_N),
        .frame_num            (frame_num),
        .num_of_history_frames(num_of_history_frames),
        .start_write          (start_write),
        .data_valid           (data_valid),
        .data_last            (data_last),
        .ready_to_write       (ready_to_write),
        .we                   (we),
        .frame_to_write       (frame_to_write),
        .offset_w             (offset_w),
        .end_pointers         (end_pointers),
        .done_write           (done_write),
        .overflow             (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pointers(input string tag);
        for (int i = 0; i < NUM_SLOTS; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(end_pointers[i]), ep_model[i]);
    endtask

    // One full frame: start (with noise on data_valid), clear, nlines accepted
    // lines with random gaps and ignored start pulses, then the done pulse.
    task automatic run_frame(input int frame, input int hist, input int nlines);
        int slot;
        int acc;
        int gap;
        bit dv;
        bit exp_we;
        slot = frame % ((hist == 0) ? 1 : hist);

        @(negedge clk);
        start_write           = 1'b1;
        frame_num             = TFW'(frame);
        num_of_history_frames = NHW'(hist);
        data_valid            = 1'($urandom_range(0, 1));
        data_last             = 1'b0;
        #1;
        check("idle_ready", 32'(ready_to_write), 0);
        check("idle_we", 32'(we), 0);

        @(negedge clk);
        start_write = 1'($urandom_range(0, 1));
        data_valid  = 1'($urandom_range(0, 1));
        data_last   = data_valid;
        #1;
        check("clear_ready", 32'(ready_to_write), 0);
        check("clear_we", 32'(we), 0);
        check("clear_done", 32'(done_write), 0);
        check("frame_latch", 32'(frame_to_write), frame);

        ep_model[slot] = 0;
        acc = 0;
        gap = 0;
        while (acc < nlines) begin
            @(negedge clk);
            dv          = ($urandom_range(0, 3) != 0) || (gap >= 2);
            data_valid  = dv;
            data_last   = dv && (acc == nlines - 1);
            start_write = ($urandom_range(0, 5) == 0);
            frame_num   = TFW'($urandom_range(0, 255));
            #1;
            exp_we = dv && (!PROTECT || acc < MAX);
            check("write_ready", 32'(ready_to_write), 1);
            check("write_we", 32'(we), 32'(exp_we));
            if (exp_we)
                check("write_offset", 32'(offset_w), acc % MAX);
            check("write_ptr", 32'(end_pointers[slot]), (acc < MAX) ? acc : MAX);
            if (acc == 0)
                check("overflow_cleared", 32'(overflow), 0);
            if (dv) begin
                acc++;
                gap = 0;
            end else begin
                gap++;
            end
        end

        @(negedge clk);
        data_valid  = 1'b1;
        data_last   = 1'b1;
        start_write = 1'b0;
        #1;
        check("done_pulse", 32'(done_write), 1);
        check("done_ready", 32'(ready_to_write), 0);
        check("done_we", 32'(we), 0);
        ep_model[slot] = (nlines < MAX) ? nlines : MAX;
        check("overflow", 32'(overflow), 32'(PROTECT && nlines > MAX));

        @(negedge clk);
        data_valid = 1'b0;
        data_last  = 1'b0;
        #1;
        check("done_one_cycle", 32'(done_write), 0);
        check("idle_after_done", 32'(ready_to_write), 0);
        check("frame_hold", 32'(frame_to_write), frame);
        check_pointers("frame_ptr");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int exp036 [NUM_SLOTS];
        exp036 = '{6, 2, 3, 4, 5};

        reset_N               = 1'b0;
        start_write           = 1'b0;
        data_valid            = 1'b0;
        data_last             = 1'b0;
        frame_num             = '0;
        num_of_history_frames = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            ep_model[i] = 0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(ready_to_write), 0);
        check("rst_we", 32'(we), 0);
        check("rst_done", 32'(done_write), 0);
        check("rst_offset", 32'(offset_w), 0);
        check("rst_frame", 32'(frame_to_write), 0);
        check("rst_overflow", 32'(overflow), 0);
        check_pointers("rst_ptr");
        @(negedge clk);
        reset_N = 1'b1;

        run_frame(7, 5, 3);
        check("basic_slot2", 32'(end_pointers[2]), 3);

        for (int f = 0; f < 6; f++)
            run_frame(f, 5, f + 1);
        for (int i = 0; i < NUM_SLOTS; i++)
            check($sformatf("wrap_slots[%0d]", i), 32'(end_pointers[i]), exp036[i]);

        run_frame(9, 0, 4);
        check("hist0_slot0", 32'(end_pointers[0]), 4);

        run_frame(200, 3, 32);
        check("long_frame_ptr", 32'(end_pointers[2]), MAX);
        run_frame(201, 3, 2);

        repeat (20)
            run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 5)),
                      int'($urandom_range(1, 35)));

        // Reset in the middle of frame 3 after two accepted lines.
        @(negedge clk);
        start_write           = 1'b1;
        frame_num             = TFW'(3);
        num_of_history_frames = NHW'(5);
        #1;
        @(negedge clk);
        start_write = 1'b0;
        #1;
        repeat (2) begin
            @(negedge clk);
            data_valid = 1'b1;
            data_last  = 1'b0;
            #1;
            check("mid_we", 32'(we), 1);
        end
        @(negedge clk);
        data_valid = 1'b0;
        reset_N    = 1'b0;
        #1;
        for (int i = 0; i < NUM_SLOTS; i++)
            ep_model[i] = 0;
        check("midrst_ready", 32'(ready_to_write), 0);
        check("midrst_done", 32'(done_write), 0);
        check("midrst_frame", 32'(frame_to_write), 0);
        check("midrst_offset", 32'(offset_w), 0);
        check_pointers("midrst_ptr");
        @(negedge clk);
        reset_N = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("post_rst_done", 32'(done_write), 0);
            check("post_rst_ready", 32'(ready_to_write), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
